pc_sequencer: RTL and testbench

- Sequential next-PC controller for the KGP-RISC core.
- Owns the PC register, the architectural Carry/Zero flag register and a small return-address stack (RAS).
- Each cycle it decodes the 3-bit PC-update code from the decoder, evaluates the branch condition and loads the PC.
- Raises a one-cycle flush on every taken redirect so fetch discards the wrong-path instruction.

---
 rtl/pc_sequencer.sv | 128 ++++++++++++
 tb/tb_pc_sequencer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Next-PC controller for the KGP-RISC core: PC register, carry/zero flags,
// return-address stack and redirect flush generation.
module pc_sequencer #(
  parameter int ADDR_W    = 32,
  parameter int RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic              stall,
  input  logic [2:0]        pc_update,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              br_flag,
  input  logic              flags_we,
  input  logic              carry_in,
  input  logic              zero_in,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_valid,
  output logic              flush,
  output logic              halted,
  output logic              carry_q,
  output logic              zero_q,
  output logic              ras_overflow,
  output logic              ras_underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  typedef enum logic [1:0] {INIT, RUN, HALT} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  sp;
  logic [CNT_W-1:0]  cnt;

  logic [ADDR_W-1:0] nxt, pc_n;
  logic              accept, c_eff, z_eff, taken, push, pop, ovf_n, unf_n;

  assign nxt      = pc + ADDR_W'(1);
  assign pc_valid = (state == RUN);
  assign halted   = (state == HALT);

  always_comb begin
    accept  = (state == RUN) && instr_valid && !stall;
    c_eff   = flags_we ? carry_in : carry_q;
    z_eff   = flags_we ? zero_in  : zero_q;
    state_n = state;
    pc_n    = pc;
    taken   = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    unf_n   = 1'b0;
    case (state)
      INIT: state_n = RUN;
      RUN: begin
        if (accept) begin
          case (pc_update)
            3'b001: begin pc_n = br_target; taken = 1'b1; end
            3'b010: begin
              taken = (c_eff == br_flag);
              pc_n  = taken ? br_target : nxt;
            end
            3'b011: begin
              taken = (z_eff == br_flag);
              pc_n  = taken ? br_target : nxt;
            end
            3'b100: begin pc_n = br_target; taken = 1'b1; push = 1'b1; end
            3'b101: begin
              if (cnt != '0) begin
                pc_n  = ras_mem[sp - PTR_W'(1)];
                taken = 1'b1;
                pop   = 1'b1;
              end else begin
                pc_n  = nxt;
                unf_n = 1'b1;
              end
            end
            3'b110: state_n = HALT;
            default: pc_n = nxt;
          endcase
        end
      end
      default: state_n = HALT;
    endcase
    ovf_n = push && (cnt == CNT_FULL);
  end

  // control / architectural state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= INIT;
      pc            <= RESET_PC;
      flush         <= 1'b0;
      carry_q       <= 1'b0;
      zero_q        <= 1'b0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
      sp            <= '0;
      cnt           <= '0;
    end else begin
      state         <= state_n;
      pc            <= pc_n;
      flush         <= taken;
      ras_overflow  <= ovf_n;
      ras_underflow <= unf_n;
      if (state != INIT && flags_we) begin
        carry_q <= carry_in;
        zero_q  <= zero_in;
      end
      if (push) begin
        sp <= sp + PTR_W'(1);
        if (cnt != CNT_FULL) cnt <= cnt + CNT_W'(1);
      end else if (pop) begin
        sp  <= sp - PTR_W'(1);
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  // A full stack wraps onto the oldest slot, so only the pointer matters here.
  always_ff @(posedge clk) begin
    if (push) ras_mem[sp] <= nxt;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios followed by random traffic,
// all compared against a queue-based behavioural model.
module tb_pc_sequencer;

  localparam int AW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst, instr_valid, stall, br_flag, flags_we, carry_in, zero_in;
  logic [2:0]    pc_update;
  logic [AW-1:0] br_target;
  logic [AW-1:0] pc;
  logic          pc_valid, flush, halted, carry_q, zero_q, ras_overflow, ras_underflow;

  int checks = 0;
  int errors = 0;

  // model state: mode 0=init, 1=running, 2=halted
  int            m_mode;
  logic [AW-1:0] m_pc;
  logic          m_c, m_z, m_flush, m_ovf, m_unf;
  logic [AW-1:0] m_ras[$];

  always #5 clk = ~clk;

  pc_sequencer #(.ADDR_W(AW), .RAS_DEPTH(DEPTH), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .stall(stall),
    .pc_update(pc_update), .br_target(br_target), .br_flag(br_flag),
    .flags_we(flags_we), .carry_in(carry_in), .zero_in(zero_in),
    .pc(pc), .pc_valid(pc_valid), .flush(flush), .halted(halted),
    .carry_q(carry_q), .zero_q(zero_q),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    logic          acc, ce, ze, tk;
    logic [AW-1:0] nx;
    nx = AW'((int'(m_pc) + 1) % 256);
    m_flush = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    if (rst) begin
      m_mode = 0; m_pc = '0; m_c = 1'b0; m_z = 1'b0;
      m_ras.delete();
      return;
    end
    acc = (m_mode == 1) && instr_valid && !stall;
    ce  = flags_we ? carry_in : m_c;
    ze  = flags_we ? zero_in  : m_z;
    if (m_mode != 0 && flags_we) begin m_c = carry_in; m_z = zero_in; end
    if (m_mode == 0) begin
      m_mode = 1;
    end else if (acc) begin
      tk = 1'b0;
      case (pc_update)
        3'd1: begin m_pc = br_target; tk = 1'b1; end
        3'd2: begin tk = (ce == br_flag); m_pc = tk ? br_target : nx; end
        3'd3: begin tk = (ze == br_flag); m_pc = tk ? br_target : nx; end
        3'd4: begin
          m_ras.push_back(nx);
          if (m_ras.size() > DEPTH) begin void'(m_ras.pop_front()); m_ovf = 1'b1; end
          m_pc = br_target; tk = 1'b1;
        end
        3'd5: begin
          if (m_ras.size() > 0) begin m_pc = m_ras.pop_back(); tk = 1'b1; end
          else begin m_pc = nx; m_unf = 1'b1; end
        end
        3'd6: m_mode = 2;
        default: m_pc = nx;
      endcase
      m_flush = tk;
    end
  endtask

  task automatic step(input logic r, input logic iv, input logic st, input logic [2:0] code,
                      input logic [AW-1:0] tgt, input logic bf, input logic fwe,
                      input logic ci, input logic zi);
    rst = r; instr_valid = iv; stall = st; pc_update = code; br_target = tgt;
    br_flag = bf; flags_we = fwe; carry_in = ci; zero_in = zi;
    @(posedge clk);
    #1;
    model_update();
    check("pc", 32'(pc), 32'(m_pc));
    check("pc_valid", 32'(pc_valid), 32'(m_mode == 1));
    check("halted", 32'(halted), 32'(m_mode == 2));
    check("flush", 32'(flush), 32'(m_flush));
    check("carry_q", 32'(carry_q), 32'(m_c));
    check("zero_q", 32'(zero_q), 32'(m_z));
    check("ras_overflow", 32'(ras_overflow), 32'(m_ovf));
    check("ras_underflow", 32'(ras_underflow), 32'(m_unf));
  endtask

  task automatic op(input logic [2:0] code, input logic [AW-1:0] tgt);
    step(0, 1, 0, code, tgt, 0, 0, 0, 0);
  endtask

  initial begin
    logic [2:0] rc;
    m_mode = 0; m_pc = '0; m_c = 0; m_z = 0; m_flush = 0; m_ovf = 0; m_unf = 0;

    // reset and init
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("init_pc_valid_low", 32'(pc_valid), 32'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("run_pc_valid_high", 32'(pc_valid), 32'd1);
    repeat (5) op(3'd0, 0);
    check("pc_after_five", 32'(pc), 32'h5);

    // conditional branch with flag bypass, then not taken
    step(0, 1, 0, 3'd2, 8'h40, 1, 1, 1, 0);
    check("bypass_taken_pc", 32'(pc), 32'h40);
    check("bypass_flush", 32'(flush), 32'd1);
    step(0, 1, 0, 3'd2, 8'h60, 0, 1, 1, 0);
    check("bypass_not_taken_pc", 32'(pc), 32'h41);
    step(0, 1, 0, 3'd3, 8'h70, 0, 0, 0, 0);

    // stall holds a pending jump
    repeat (3) step(0, 1, 1, 3'd1, 8'h80, 0, 0, 0, 0);
    step(0, 1, 0, 3'd1, 8'h80, 0, 0, 0, 0);
    check("stall_release_pc", 32'(pc), 32'h80);

    // five calls overflow a 4-deep stack, five returns underflow once
    op(3'd1, 8'h01);
    for (int i = 1; i <= 5; i++) begin
      op(3'd4, 8'(i * 16));
      if (i < 5) op(3'd0, 0);
    end
    check("ovf_on_fifth_call", 32'(ras_overflow), 32'd1);
    for (int i = 0; i < 5; i++) op(3'd5, 0);
    check("underflow_on_fifth_ret", 32'(ras_underflow), 32'd1);

    // halt, ignored codes, flags still written, reset mid-halt
    op(3'd1, 8'h07);
    op(3'd6, 0);
    check("halt_pc", 32'(pc), 32'h7);
    op(3'd1, 8'h33);
    step(0, 1, 0, 3'd0, 0, 0, 1, 1, 1);
    step(1, 1, 0, 3'd0, 0, 0, 0, 0, 0);
    check("reset_from_halt", 32'(halted), 32'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // wrap with reserved code
    op(3'd1, 8'hFF);
    op(3'd7, 0);
    check("wrap_pc", 32'(pc), 32'h00);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      rc = 3'($urandom_range(0, 7));
      if (rc == 3'd6 && $urandom_range(0, 7) != 0) rc = 3'd0;
      step(($urandom_range(0, 63) == 0) || (m_mode == 2 && $urandom_range(0, 3) == 0),
           $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, rc,
           8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
